// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types, widths and helpers for the writeback unit
//
// Contents:
//   WB_DATA_W / WB_ADDR_W / WB_PC_W : widths the FIFO entry is built from
//   wb_sel_t   : result kind from execute (ALU, MUL, LINK, NONE)
//   wb_state_t : writeback FSM states
//   wb_entry_t : one queued result as stored in the FIFO
//   link_value : zero-extended (pc + 1) wrapped to PC width
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 4;
    localparam int WB_PC_W   = 4;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MUL  = 2'b01,
        WB_LINK = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WRITE    = 2'b01,
        WRITE_HI = 2'b10
    } wb_state_t;

    typedef struct packed {
        wb_sel_t                sel;
        logic [WB_ADDR_W-1:0]   rd;
        logic [WB_ADDR_W-1:0]   rd_hi;
        logic [WB_DATA_W-1:0]   data_lo;
        logic [WB_DATA_W-1:0]   data_hi;
        logic [WB_PC_W-1:0]     pc;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

    // Return address of a jump: pc + 1, wrapping inside the PC width.
    function automatic logic [WB_DATA_W-1:0] link_value(input logic [WB_PC_W-1:0] pc);
        logic [WB_PC_W-1:0] nxt;
        nxt = pc + {{(WB_PC_W-1){1'b0}}, 1'b1};
        return {{(WB_DATA_W-WB_PC_W){1'b0}}, nxt};
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// rtl/wb_unit_if.sv - execute-result handshake and register-file write port bundle
//
// Signals:
//   ex_valid/ex_ready        : result handshake from execute
//   ex_sel, ex_rd, ex_rd_hi  : result kind and destination(s)
//   ex_data_lo/hi, ex_pc     : result payload
//   rf_we/rf_waddr/rf_wdata  : registered register-file write port
//   wb_busy                  : unit holds or is issuing work
//   byp_valid/addr/data      : next-edge write preview (only with WB_BYPASS_EN)
// Modports: slave = writeback unit, master = execute / register-file side.
interface wb_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 4
) ();

    logic              ex_valid;
    logic              ex_ready;
    logic [1:0]        ex_sel;
    logic [ADDR_W-1:0] ex_rd;
    logic [ADDR_W-1:0] ex_rd_hi;
    logic [DATA_W-1:0] ex_data_lo;
    logic [DATA_W-1:0] ex_data_hi;
    logic [PC_W-1:0]   ex_pc;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_busy;

`ifdef WB_BYPASS_EN
    logic              byp_valid;
    logic [ADDR_W-1:0] byp_addr;
    logic [DATA_W-1:0] byp_data;
`endif

    modport slave (
        input  ex_valid, ex_sel, ex_rd, ex_rd_hi, ex_data_lo, ex_data_hi, ex_pc,
        output ex_ready, rf_we, rf_waddr, rf_wdata, wb_busy
`ifdef WB_BYPASS_EN
        , output byp_valid, byp_addr, byp_data
`endif
    );

    modport master (
        output ex_valid, ex_sel, ex_rd, ex_rd_hi, ex_data_lo, ex_data_hi, ex_pc,
        input  ex_ready, rf_we, rf_waddr, rf_wdata, wb_busy
`ifdef WB_BYPASS_EN
        , input byp_valid, byp_addr, byp_data
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - power-of-two circular buffer holding pending writeback results
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset (empties the buffer)
//   push, push_data      : enqueue (ignored when full)
//   pop                  : dequeue head (ignored when empty)
//   pop_data             : current head entry
//   count, full, empty   : occupancy
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read until count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback unit: queues execute results and drives the register-file write port
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset; discards queued results and any half-done MUL
//   bus    : wb_unit_if.slave - ex_* handshake in, rf_* write port and wb_busy out
// Optional: define WB_BYPASS_EN to drive bus.byp_valid/byp_addr/byp_data, a combinational
// preview of the write that will be registered onto rf_* at the next edge.
// The FIFO entry layout comes from wb_pkg, so DATA_W/ADDR_W/PC_W follow the package widths.
module wb_unit
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int PC_W   = WB_PC_W,
    parameter int DEPTH  = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t         state;
    wb_state_t         nxt_state;
    logic              nxt_we;
    logic [ADDR_W-1:0] nxt_waddr;
    logic [DATA_W-1:0] nxt_wdata;
    logic              nxt_busy;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;
    logic              go_hi;
    wb_entry_t         push_entry;
    wb_entry_t         head;
    logic [WB_ENTRY_W-1:0] head_bits;

    // Ready depends only on occupancy (and reset), never on ex_valid, so a
    // pop in the same cycle does not open a slot when the FIFO is full.
    assign bus.ex_ready = !fifo_full && rst_n;
    assign push         = bus.ex_valid && bus.ex_ready;

    always_comb begin
        push_entry         = '0;
        push_entry.sel     = wb_sel_t'(bus.ex_sel);
        push_entry.rd      = bus.ex_rd;
        push_entry.rd_hi   = bus.ex_rd_hi;
        push_entry.data_lo = bus.ex_data_lo;
        push_entry.data_hi = bus.ex_data_hi;
        push_entry.pc      = bus.ex_pc;
    end

    wb_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_bits),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head = wb_entry_t'(head_bits);

    // Next-state of the write port. IDLE and WRITE issue the head the same
    // way: an entry landing in an empty unit is written on the very next
    // edge, which gives the one-cycle accept-to-write latency.
    always_comb begin
        nxt_we    = 1'b0;
        nxt_waddr = bus.rf_waddr;
        nxt_wdata = bus.rf_wdata;
        pop       = 1'b0;
        go_hi     = 1'b0;

        unique case (state)
            IDLE, WRITE: begin
                if (!fifo_empty) begin
                    unique case (head.sel)
                        WB_ALU: begin
                            nxt_we    = 1'b1;
                            nxt_waddr = head.rd;
                            nxt_wdata = head.data_lo;
                            pop       = 1'b1;
                        end
                        WB_MUL: begin
                            // Low word now; the entry stays queued for the high word.
                            nxt_we    = 1'b1;
                            nxt_waddr = head.rd;
                            nxt_wdata = head.data_lo;
                            go_hi     = 1'b1;
                        end
                        WB_LINK: begin
                            nxt_we    = 1'b1;
                            nxt_waddr = head.rd;
                            nxt_wdata = link_value(head.pc);
                            pop       = 1'b1;
                        end
                        WB_NONE: begin
                            pop       = 1'b1;
                        end
                    endcase
                end
            end
            WRITE_HI: begin
                nxt_we    = 1'b1;
                nxt_waddr = head.rd_hi;
                nxt_wdata = head.data_hi;
                pop       = 1'b1;
            end
            default: begin
                pop = 1'b0;
            end
        endcase

        // Occupancy after this edge, counting a same-cycle accept.
        count_after = count + CNT_W'(push) - CNT_W'(pop);

        if (go_hi)
            nxt_state = WRITE_HI;
        else if (count_after != '0)
            nxt_state = WRITE;
        else
            nxt_state = IDLE;

        // Busy also covers the cycle in which the final write is on the port.
        nxt_busy = (count_after != '0) || (nxt_state != IDLE) || nxt_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.wb_busy  <= 1'b0;
        end else begin
            state        <= nxt_state;
            bus.rf_we    <= nxt_we;
            bus.rf_waddr <= nxt_waddr;
            bus.rf_wdata <= nxt_wdata;
            bus.wb_busy  <= nxt_busy;
        end
    end

`ifdef WB_BYPASS_EN
    // Reset blocks the preview because the pending write will not happen.
    assign bus.byp_valid = nxt_we && rst_n;
    assign bus.byp_addr  = nxt_waddr;
    assign bus.byp_data  = nxt_wdata;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - scoreboard testbench for wb_unit
module tb_wb_unit;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_unit_if #(.DATA_W(32), .ADDR_W(4), .PC_W(4)) bus ();

    wb_unit #(.DATA_W(32), .ADDR_W(4), .PC_W(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  ready_low_cycles = 0;
    int  write_count = 0;

    // Scoreboard: every write on the port must match the oldest expectation.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.rf_we === 1'b1) begin
            write_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
                end
            end
        end
        if (rst_n && bus.ex_valid === 1'b1 && bus.ex_ready !== 1'b1)
            ready_low_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.ex_valid   = 1'b0;
        bus.ex_sel     = 2'b00;
        bus.ex_rd      = '0;
        bus.ex_rd_hi   = '0;
        bus.ex_data_lo = '0;
        bus.ex_data_hi = '0;
        bus.ex_pc      = '0;
    endtask

    // Presents one result, waits (bounded) for ready, and records the
    // writes it should produce once the accepting edge has passed.
    task automatic send(input logic [1:0] sel, input logic [3:0] rd, input logic [3:0] rd_hi,
                        input logic [31:0] lo, input logic [31:0] hi, input logic [3:0] pc);
        int  waited;
        wr_t e;
        logic [3:0] pc_next;
        @(negedge clk);
        bus.ex_valid   = 1'b1;
        bus.ex_sel     = sel;
        bus.ex_rd      = rd;
        bus.ex_rd_hi   = rd_hi;
        bus.ex_data_lo = lo;
        bus.ex_data_hi = hi;
        bus.ex_pc      = pc;
        waited = 0;
        while (bus.ex_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (bus.ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: ex_ready=%b after %0d cycles, required 1", bus.ex_ready, waited);
            bus.ex_valid = 1'b0;
            return;
        end
        @(posedge clk);
        case (sel)
            2'b00: begin e.addr = rd; e.data = lo; exp_q.push_back(e); end
            2'b01: begin
                e.addr = rd;    e.data = lo; exp_q.push_back(e);
                e.addr = rd_hi; e.data = hi; exp_q.push_back(e);
            end
            2'b10: begin
                pc_next = pc + 4'd1;
                e.addr = rd; e.data = {28'h0, pc_next}; exp_q.push_back(e);
            end
            default: ;
        endcase
    endtask

    task automatic stop_valid();
        @(negedge clk);
        bus.ex_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.wb_busy !== 1'b0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.wb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d wb_busy=%b, required 0 and 0", name, exp_q.size(), bus.wb_busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        bus.ex_valid   = 1'b1;
        bus.ex_rd      = 4'd9;
        bus.ex_data_lo = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b, required 0", bus.rf_we); end
            if (bus.ex_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ex_ready: got %b, required 0", bus.ex_ready); end
            if (bus.wb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_wb_busy: got %b, required 0", bus.wb_busy); end
        end
        n_checks += 2;
        if (bus.rf_waddr !== 4'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d, required 0", bus.rf_waddr); end
        if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h, required 0", bus.rf_wdata); end
        bus.ex_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_rf_we: got %b, required 0", bus.rf_we); end
            if (bus.wb_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b, required 0", bus.wb_busy); end
            if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b, required 1", bus.ex_ready); end
        end
    endtask

    task automatic test_alu();
        send(2'b00, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'h0, 4'h0);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        n_checks += 2;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_cycle_n_we: got %b, required 0", bus.rf_we); end
        if (bus.wb_busy !== 1'b1) begin n_fail++; $display("FAIL alu_cycle_n_busy: got %b, required 1", bus.wb_busy); end
        @(negedge clk);
        n_checks += 4;
        if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b, required 1", bus.rf_we); end
        if (bus.rf_waddr !== 4'd3) begin n_fail++; $display("FAIL alu_waddr: got %0d, required 3", bus.rf_waddr); end
        if (bus.rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alu_wdata: got %h, required deadbeef", bus.rf_wdata); end
        if (bus.wb_busy !== 1'b1) begin n_fail++; $display("FAIL alu_write_busy: got %b, required 1", bus.wb_busy); end
        @(negedge clk);
        n_checks += 2;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_after_we: got %b, required 0", bus.rf_we); end
        if (bus.wb_busy !== 1'b0) begin n_fail++; $display("FAIL alu_after_busy: got %b, required 0", bus.wb_busy); end
    endtask

    task automatic test_mul();
        logic [3:0]  exp_addr [3];
        logic [31:0] exp_data [3];
        logic        exp_we   [3];
        exp_we[0] = 1'b1; exp_addr[0] = 4'd4; exp_data[0] = 32'h1;
        exp_we[1] = 1'b1; exp_addr[1] = 4'd5; exp_data[1] = 32'h2;
        exp_we[2] = 1'b0; exp_addr[2] = 4'd0; exp_data[2] = 32'h0;
        send(2'b01, 4'd4, 4'd5, 32'h1, 32'h2, 4'h0);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        n_checks++;
        if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_n: got %b, required 1", bus.ex_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (bus.rf_we !== exp_we[i]) begin n_fail++; $display("FAIL mul_we[%0d]: got %b, required %b", i, bus.rf_we, exp_we[i]); end
            if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready[%0d]: got %b, required 1", i, bus.ex_ready); end
            if (exp_we[i]) begin
                n_checks++;
                if (bus.rf_waddr !== exp_addr[i] || bus.rf_wdata !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL mul_write[%0d]: got %0d<-%h, required %0d<-%h", i,
                             bus.rf_waddr, bus.rf_wdata, exp_addr[i], exp_data[i]);
                end
            end
        end
        // Same destination twice: the high word must land last.
        send(2'b01, 4'd6, 4'd6, 32'hAAAA_0001, 32'hBBBB_0002, 4'h0);
        stop_valid();
        drain("mul_same_rd");
    endtask

    task automatic test_link();
        send(2'b10, 4'd14, 4'd0, 32'h0, 32'h0, 4'hF);
        stop_valid();
        drain("link_wrap");
        send(2'b10, 4'd14, 4'd0, 32'h0, 32'h0, 4'h6);
        stop_valid();
        drain("link_plain");
        send(2'b11, 4'd7, 4'd0, 32'hFFFF_FFFF, 32'h0, 4'h0);
        stop_valid();
        drain("none_kind");
    endtask

    task automatic test_back_to_back();
        int start_writes;
        ready_low_cycles = 0;
        start_writes = write_count;
        for (int i = 0; i < 6; i++)
            send(2'b00, 4'(i + 1), 4'd0, $urandom, 32'h0, 4'h0);
        send(2'b10, 4'd2, 4'd0, 32'h0, 32'h0, 4'h9);
        stop_valid();
        drain("back_to_back");
        n_checks += 2;
        if (ready_low_cycles != 0) begin n_fail++; $display("FAIL b2b_ready_low: got %0d cycles, required 0", ready_low_cycles); end
        if (write_count - start_writes != 7) begin n_fail++; $display("FAIL b2b_write_count: got %0d, required 7", write_count - start_writes); end
    endtask

    task automatic test_backpressure();
        int start_writes;
        ready_low_cycles = 0;
        start_writes = write_count;
        for (int i = 0; i < 3; i++)
            send(2'b01, 4'(2 * i), 4'(2 * i + 1), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 4'h0);
        stop_valid();
        drain("backpressure");
        n_checks += 2;
        if (ready_low_cycles == 0) begin n_fail++; $display("FAIL bp_ready_drop: got %0d low cycles, required >0", ready_low_cycles); end
        if (write_count - start_writes != 6) begin n_fail++; $display("FAIL bp_write_count: got %0d, required 6", write_count - start_writes); end
    endtask

    task automatic test_reset_mid_mul();
        send(2'b01, 4'd4, 4'd5, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 4'h0);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_mul_lo: got we=%b addr=%0d, required we=1 addr=4", bus.rf_we, bus.rf_waddr);
        end
        #1;
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks += 5;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_mul_we: got %b, required 0", bus.rf_we); end
        if (bus.rf_waddr !== 4'd0) begin n_fail++; $display("FAIL mid_mul_waddr: got %0d, required 0", bus.rf_waddr); end
        if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL mid_mul_wdata: got %h, required 0", bus.rf_wdata); end
        if (bus.wb_busy !== 1'b0) begin n_fail++; $display("FAIL mid_mul_busy: got %b, required 0", bus.wb_busy); end
        if (bus.ex_ready !== 1'b0) begin n_fail++; $display("FAIL mid_mul_ready: got %b, required 0", bus.ex_ready); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.wb_busy !== 1'b0) begin n_fail++; $display("FAIL mid_mul_after_busy: got %b, required 0", bus.wb_busy); end
        send(2'b00, 4'd8, 4'd0, 32'hC0DE_0008, 32'h0, 4'h0);
        stop_valid();
        drain("after_reset");
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_alu();
        test_mul();
        test_link();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
